// File: rtl/i_prefetch_ctrl.sv
// Instruction prefetch controller: sequential byte fetch from i_mem into a
// small {addr,data} FIFO, with redirect flush and stale-reply discard.
module i_prefetch_ctrl #(
    parameter int i_addr_width = 16,
    parameter int DEPTH = 4,
    parameter logic [i_addr_width-1:0] RESET_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect,
    input  logic [i_addr_width-1:0] redirect_addr,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    output logic [i_addr_width-1:0] out_addr,
    input  logic                    out_pop,
    output logic                    mem_req,
    output logic [i_addr_width-1:0] mem_addr,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rdata
);
    localparam int AW = i_addr_width;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [AW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic          discard_q, discard_d;
    logic          push;
    logic          pop;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [7:0]    data_mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fetch_ptr_d = fetch_ptr_q;
        discard_d   = discard_q;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_ptr_d = redirect_addr;
                end else if (count_q < FULL) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_ptr_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    if (redirect) begin
                        fetch_ptr_d = redirect_addr;
                    end else if (!discard_q) begin
                        push        = 1'b1;
                        fetch_ptr_d = mem_addr_q + AW'(1);
                    end
                end else if (redirect) begin
                    // Request stays in flight; its reply must be dropped.
                    discard_d   = 1'b1;
                    fetch_ptr_d = redirect_addr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_ADDR;
            fetch_ptr_q <= RESET_ADDR;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fetch_ptr_q <= fetch_ptr_d;
            discard_q   <= discard_d;
        end
    end

    assign pop = out_pop && (count_q != '0) && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= mem_addr_q;
            data_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    // Head outputs read as zero while empty so stale entries never leak.
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? data_mem[rd_ptr_q] : 8'h00;
    assign out_addr  = out_valid ? addr_mem[rd_ptr_q] : '0;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_i_prefetch_ctrl.sv
// Directed bench for i_prefetch_ctrl with a behavioural i_mem
// whose reply byte is 0x10 + addr[7:0].
module tb_i_prefetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        out_pop = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int cnt = 0;
    bit given = 0;

    i_prefetch_ctrl dut (
        .clk(clk), .rst(rst),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
        .out_pop(out_pop),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!mem_req || rst) begin
            mem_ack = 0; cnt = 0; given = 0;
        end else if (given) begin
            mem_ack = 0;
        end else if (cnt + 1 >= lat) begin
            mem_ack = 1;
            mem_rdata = 8'h10 + mem_addr[7:0];
            given = 1;
        end else begin
            cnt++;
            mem_ack = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rise(input string nm);
        bit prev;
        bit hit;
        prev = mem_req;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            if (mem_req && !prev) hit = 1;
            prev = mem_req;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL %s: mem_req rise timeout", nm);
        end
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 60 && !out_valid; i++) step();
        tests++;
        if (!out_valid) begin
            fails++;
            $display("FAIL %s: out_valid timeout", nm);
        end
    endtask

    task automatic test_reset();
        #1;
        tests += 5;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", mem_req); end
        if (mem_addr !== 16'h0) begin fails++; $display("FAIL rst_addr got %h want 0000", mem_addr); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin fails++; $display("FAIL rst_data got %h want 00", out_data); end
        if (out_addr !== 16'h0) begin fails++; $display("FAIL rst_oaddr got %h want 0000", out_addr); end
    endtask

    task automatic test_fill();
        step();
        rst = 0;
        step();
        tests += 2;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL fill_req1 got %b want 1", mem_req); end
        if (mem_addr !== 16'h0) begin fails++; $display("FAIL fill_addr1 got %h want 0000", mem_addr); end
        repeat (20) step();
        tests += 4;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL fill_idle got %b want 0", mem_req); end
        if (out_valid !== 1'b1) begin fails++; $display("FAIL fill_valid got %b want 1", out_valid); end
        if (out_addr !== 16'h0) begin fails++; $display("FAIL fill_head got %h want 0000", out_addr); end
        if (out_data !== 8'h10) begin fails++; $display("FAIL fill_data got %h want 10", out_data); end
    endtask

    task automatic test_drain();
        int exp_a;
        bit saw_req;
        exp_a = 0;
        saw_req = 0;
        for (int i = 0; i < 80 && exp_a < 8; i++) begin
            step();
            if (mem_req) saw_req = 1;
            if (out_valid) begin
                tests += 2;
                if (out_addr !== 16'(exp_a)) begin
                    fails++;
                    $display("FAIL drain_addr got %h want %h", out_addr, 16'(exp_a));
                end
                if (out_data !== 8'(8'h10 + exp_a)) begin
                    fails++;
                    $display("FAIL drain_data got %h want %h", out_data, 8'(8'h10 + exp_a));
                end
                out_pop = 1;
                exp_a++;
            end else begin
                out_pop = 0;
            end
        end
        out_pop = 0;
        tests += 2;
        if (exp_a != 8) begin fails++; $display("FAIL drain_count got %0d want 8", exp_a); end
        if (!saw_req) begin fails++; $display("FAIL drain_refill got 0 want 1"); end
    endtask

    task automatic test_redirect_req();
        logic [15:0] held;
        lat = 3;
        out_pop = 1;
        wait_rise("rreq_issue");
        out_pop = 0;
        held = mem_addr;
        redirect = 1;
        redirect_addr = 16'h0100;
        step();
        redirect = 0;
        tests += 3;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL rreq_hold_req got %b want 1", mem_req); end
        if (mem_addr !== held) begin fails++; $display("FAIL rreq_hold_addr got %h want %h", mem_addr, held); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rreq_flush got %b want 0", out_valid); end
        wait_rise("rreq_restart");
        tests++;
        if (mem_addr !== 16'h0100) begin fails++; $display("FAIL rreq_next got %h want 0100", mem_addr); end
        wait_valid("rreq_pop");
        tests += 2;
        if (out_addr !== 16'h0100) begin fails++; $display("FAIL rreq_head got %h want 0100", out_addr); end
        if (out_data !== 8'h10) begin fails++; $display("FAIL rreq_data got %h want 10", out_data); end
    endtask

    task automatic test_redirect_ack();
        lat = 1;
        out_pop = 1;
        for (int i = 0; i < 60 && !mem_ack; i++) step();
        tests++;
        if (!mem_ack) begin fails++; $display("FAIL rack_wait: ack timeout"); end
        redirect = 1;
        redirect_addr = 16'h0200;
        step();
        redirect = 0;
        out_pop = 0;
        tests += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rack_flush got %b want 0", out_valid); end
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rack_gap got %b want 0", mem_req); end
        wait_rise("rack_restart");
        tests++;
        if (mem_addr !== 16'h0200) begin fails++; $display("FAIL rack_next got %h want 0200", mem_addr); end
        wait_valid("rack_pop");
        tests += 2;
        if (out_addr !== 16'h0200) begin fails++; $display("FAIL rack_head got %h want 0200", out_addr); end
        if (out_data !== 8'h10) begin fails++; $display("FAIL rack_data got %h want 10", out_data); end
    endtask

    task automatic test_wrap();
        out_pop = 0;
        redirect = 1;
        redirect_addr = 16'hFFFF;
        step();
        redirect = 0;
        wait_valid("wrap_first");
        tests += 2;
        if (out_addr !== 16'hFFFF) begin fails++; $display("FAIL wrap_a0 got %h want ffff", out_addr); end
        if (out_data !== 8'h0F) begin fails++; $display("FAIL wrap_d0 got %h want 0f", out_data); end
        out_pop = 1;
        step();
        out_pop = 0;
        wait_valid("wrap_second");
        tests += 2;
        if (out_addr !== 16'h0000) begin fails++; $display("FAIL wrap_a1 got %h want 0000", out_addr); end
        if (out_data !== 8'h10) begin fails++; $display("FAIL wrap_d1 got %h want 10", out_data); end
    endtask

    task automatic test_reset_mid();
        lat = 3;
        out_pop = 1;
        wait_rise("rmid_issue");
        out_pop = 0;
        rst = 1;
        #1;
        tests += 2;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_req got %b want 0", mem_req); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        lat = 1;
        step();
        step();
        rst = 0;
        step();
        tests += 2;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL rmid_resume got %b want 1", mem_req); end
        if (mem_addr !== 16'h0) begin fails++; $display("FAIL rmid_addr got %h want 0000", mem_addr); end
        wait_valid("rmid_pop");
        tests += 2;
        if (out_addr !== 16'h0) begin fails++; $display("FAIL rmid_head got %h want 0000", out_addr); end
        if (out_data !== 8'h10) begin fails++; $display("FAIL rmid_data got %h want 10", out_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_redirect_req();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
